// File: rtl/serializer_bank_pkg.sv
// Shared constants for the HDMI output serializer: TMDS control words,
// default word size and a counter-width helper.
package serializer_bank_pkg;

  // Default bits per TMDS word.
  localparam int DEFAULT_SIZE = 10;

  // TMDS control-period symbols (C1,C0 = 00/01/10/11).
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  // Symbol sent on a lane when the encoder has nothing ready.
  localparam logic [9:0] TMDS_IDLE_WORD = TMDS_CTRL_00;

  // Width of a counter spanning 0..size-1; never narrower than one bit.
  function automatic int cnt_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/serializer_lane.sv
// One lane of the serializer: a SIZE-bit register that loads a word and then
// rotates it so the output bit walks through the word and the word survives
// a full rotation intact.
module serializer_lane
  import serializer_bank_pkg::*;
#(
  parameter int SIZE      = DEFAULT_SIZE,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            load,
  input  logic            shift,
  input  logic [SIZE-1:0] load_word,
  output logic            out_bit
);

  logic [SIZE-1:0] shift_reg;

  // Load a new word or rotate the current one toward the output end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
    end else if (clear) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= load_word;
    end else if (shift) begin
      if (MSB_FIRST) begin
        shift_reg <= {shift_reg[SIZE-2:0], shift_reg[SIZE-1]};
      end else begin
        shift_reg <= {shift_reg[0], shift_reg[SIZE-1:1]};
      end
    end
  end

  // The output bit is a register bit, so s_out is glitch-free.
  assign out_bit = MSB_FIRST ? shift_reg[SIZE-1] : shift_reg[0];

endmodule

// File: rtl/serializer_bank.sv
// Multi-lane parallel-to-serial converter. A shared bit counter paces the
// word loads; all lanes load and rotate in lockstep. Missing words are
// replaced by IDLE_WORD and flagged through a sticky underrun bit.
module serializer_bank
  import serializer_bank_pkg::*;
#(
  parameter int              SIZE      = DEFAULT_SIZE,
  parameter int              CHANNELS  = 3,
  parameter bit              MSB_FIRST = 1'b0,
  parameter logic [SIZE-1:0] IDLE_WORD = SIZE'(TMDS_IDLE_WORD)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [CHANNELS*SIZE-1:0] p_data,
  input  logic                     p_valid,
  output logic                     p_ready,
  output logic [CHANNELS-1:0]      s_out,
  output logic                     word_start,
  output logic                     underrun,
  input  logic                     underrun_clr
);

  localparam int            CW       = cnt_width(SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);

  logic [CW-1:0]            cnt_reg;
  logic                     word_start_reg;
  logic                     underrun_reg;
  logic                     at_last;
  logic                     load;
  logic                     shift;
  logic [CHANNELS*SIZE-1:0] load_bus;

  assign at_last = (cnt_reg == CNT_LAST);

  // A word slot opens once per word period; p_valid never gates readiness.
  assign p_ready = enable & ~clear & at_last;
  assign load    = p_ready;
  assign shift   = enable & ~clear & ~at_last;

  // Underrun substitutes the idle symbol on every lane.
  assign load_bus = p_valid ? p_data : {CHANNELS{IDLE_WORD}};

  // Bit counter: wraps to 0 on the load edge, holds while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= CNT_LAST;
    end else if (clear) begin
      cnt_reg <= CNT_LAST;
    end else if (enable) begin
      cnt_reg <= at_last ? '0 : cnt_reg + CW'(1);
    end
  end

  // word_start marks the first bit: set by a load, dropped on the next enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_start_reg <= 1'b0;
    end else if (clear) begin
      word_start_reg <= 1'b0;
    end else if (enable) begin
      word_start_reg <= at_last;
    end
  end

  // Sticky underrun: a substitution wins over a same-cycle clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_reg <= 1'b0;
    end else if (clear) begin
      underrun_reg <= 1'b0;
    end else if (load && !p_valid) begin
      underrun_reg <= 1'b1;
    end else if (underrun_clr) begin
      underrun_reg <= 1'b0;
    end
  end

  assign word_start = word_start_reg;
  assign underrun   = underrun_reg;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    serializer_lane #(
      .SIZE      (SIZE),
      .MSB_FIRST (MSB_FIRST)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .load      (load),
      .shift     (shift),
      .load_word (load_bus[gi*SIZE +: SIZE]),
      .out_bit   (s_out[gi])
    );
  end

endmodule

// File: tb/tb_serializer_bank.sv
// Testbench for serializer_bank: four configurations share one clock. A
// source process queues the expected word at every handshake (data or idle);
// a monitor process pops it on the load and compares every serial bit,
// word_start, p_ready and underrun. Directed checks add hand-computed values.
module tb_serializer_bank;

  localparam int NI = 4;

  typedef struct {
    int          id;
    logic [63:0] word;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_v   [NI];
  logic        enable_v  [NI];
  logic        clear_v   [NI];
  logic        p_valid_v [NI];
  logic        uclr_v    [NI];
  logic [63:0] p_data_v  [NI];
  logic        p_ready_v [NI];
  logic        ws_v      [NI];
  logic        ur_v      [NI];
  logic [3:0]  s_out_v   [NI];

  logic [2:0] s_out0;
  logic [0:0] s_out1;
  logic [0:0] s_out2;
  logic [3:0] s_out3;

  assign s_out_v[0] = {1'b0, s_out0};
  assign s_out_v[1] = {3'b000, s_out1};
  assign s_out_v[2] = {3'b000, s_out2};
  assign s_out_v[3] = s_out3;

  // Per-instance configuration used by the scoreboard.
  int          size_c [NI] = '{10, 10, 2, 16};
  int          chan_c [NI] = '{3, 1, 1, 4};
  bit          msb_c  [NI] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [15:0] idle_c [NI] = '{16'h0354, 16'h0354, 16'h0002, 16'hA5C3};

  // Hand-computed serial sequences.
  bit exp_l0   [10] = '{1, 1, 0, 1, 0, 1, 0, 1, 0, 1};  // 0x2AB LSB first
  bit exp_idle [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 1};  // 1101010100 LSB first
  bit exp_msb  [10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1};  // 1000000001 MSB first

  serializer_bank #(.SIZE(10), .CHANNELS(3), .MSB_FIRST(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n_v[0]), .clear(clear_v[0]), .enable(enable_v[0]),
    .p_data(p_data_v[0][29:0]), .p_valid(p_valid_v[0]), .p_ready(p_ready_v[0]),
    .s_out(s_out0), .word_start(ws_v[0]), .underrun(ur_v[0]), .underrun_clr(uclr_v[0]));

  serializer_bank #(.SIZE(10), .CHANNELS(1), .MSB_FIRST(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n_v[1]), .clear(clear_v[1]), .enable(enable_v[1]),
    .p_data(p_data_v[1][9:0]), .p_valid(p_valid_v[1]), .p_ready(p_ready_v[1]),
    .s_out(s_out1), .word_start(ws_v[1]), .underrun(ur_v[1]), .underrun_clr(uclr_v[1]));

  serializer_bank #(.SIZE(2), .CHANNELS(1), .MSB_FIRST(1'b0), .IDLE_WORD(2'b10)) u_dut2 (
    .clk(clk), .rst_n(rst_n_v[2]), .clear(clear_v[2]), .enable(enable_v[2]),
    .p_data(p_data_v[2][1:0]), .p_valid(p_valid_v[2]), .p_ready(p_ready_v[2]),
    .s_out(s_out2), .word_start(ws_v[2]), .underrun(ur_v[2]), .underrun_clr(uclr_v[2]));

  serializer_bank #(.SIZE(16), .CHANNELS(4), .MSB_FIRST(1'b0), .IDLE_WORD(16'hA5C3)) u_dut3 (
    .clk(clk), .rst_n(rst_n_v[3]), .clear(clear_v[3]), .enable(enable_v[3]),
    .p_data(p_data_v[3]), .p_valid(p_valid_v[3]), .p_ready(p_ready_v[3]),
    .s_out(s_out3), .word_start(ws_v[3]), .underrun(ur_v[3]), .underrun_clr(uclr_v[3]));

  int checks = 0;
  int errors = 0;

  exp_t sb_q [$];
  exp_t push_e;

  // Monitor model state per instance.
  int          mcnt   [NI];
  int          bitk   [NI];
  bit          active [NI];
  bit          mur    [NI];
  bit          adv_p  [NI];
  bit          load_p [NI];
  bit          nval_p [NI];
  bit          clr_p  [NI];
  bit          uclr_p [NI];
  logic [63:0] cur    [NI];

  task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, id, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] idle_rep(input int i);
    logic [63:0] w = '0;
    for (int c = 0; c < chan_c[i]; c++)
      for (int b = 0; b < size_c[i]; b++)
        w[c*size_c[i] + b] = idle_c[i][b];
    return w;
  endfunction

  task automatic model_reset(input int i);
    mcnt[i]   = size_c[i] - 1;
    bitk[i]   = 0;
    active[i] = 1'b0;
    mur[i]    = 1'b0;
  endtask

  task automatic pop_word(input int id, output logic [63:0] w, output bit ok);
    ok = 1'b0;
    w  = '0;
    for (int j = 0; j < sb_q.size(); j++) begin
      if (sb_q[j].id == id) begin
        w  = sb_q[j].word;
        ok = 1'b1;
        sb_q.delete(j);
        return;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  // Source side: whatever is offered at a handshake slot becomes the expected word.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst_n_v[i] && p_ready_v[i]) begin
        push_e.id   = i;
        push_e.word = p_valid_v[i] ? p_data_v[i] : idle_rep(i);
        sb_q.push_back(push_e);
      end
    end
  end

  // Monitor: advance the model by the previous edge, then compare all outputs.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic [63:0] w;
      logic [3:0]  exp_s;
      bit          ok;
      if (clr_p[i]) begin
        model_reset(i);
      end else begin
        if (adv_p[i]) begin
          if (load_p[i]) begin
            pop_word(i, w, ok);
            chk("sb_word_present", i, 64'(ok), 64'd1);
            cur[i]    = w;
            active[i] = ok;
            bitk[i]   = 0;
            mcnt[i]   = 0;
          end else begin
            bitk[i]++;
            mcnt[i]++;
          end
        end
        if (nval_p[i]) mur[i] = 1'b1;
        else if (uclr_p[i]) mur[i] = 1'b0;
      end
      if (!rst_n_v[i]) model_reset(i);

      exp_s = '0;
      if (active[i]) begin
        for (int c = 0; c < chan_c[i]; c++)
          exp_s[c] = cur[i][c*size_c[i] + (msb_c[i] ? size_c[i] - 1 - bitk[i] : bitk[i])];
      end
      chk("s_out", i, 64'(s_out_v[i]), 64'(exp_s));
      chk("word_start", i, 64'(ws_v[i]), 64'(active[i] && bitk[i] == 0));
      chk("underrun", i, 64'(ur_v[i]), 64'(mur[i]));
      chk("p_ready", i, 64'(p_ready_v[i]),
          64'(enable_v[i] && !clear_v[i] && mcnt[i] == size_c[i] - 1));

      adv_p[i]  = rst_n_v[i] && enable_v[i] && !clear_v[i];
      load_p[i] = adv_p[i] && (mcnt[i] == size_c[i] - 1);
      nval_p[i] = load_p[i] && !p_valid_v[i];
      clr_p[i]  = clear_v[i] || !rst_n_v[i];
      uclr_p[i] = uclr_v[i];
    end
  end

  initial begin
    logic [3:0] s_hold;
    logic       ws_hold;
    for (int i = 0; i < NI; i++) begin
      rst_n_v[i] = 1'b0;  enable_v[i] = 1'b0; clear_v[i] = 1'b0;
      p_valid_v[i] = 1'b0; uclr_v[i] = 1'b0;  p_data_v[i] = '0;
      clr_p[i] = 1'b1; adv_p[i] = 1'b0; load_p[i] = 1'b0;
      nval_p[i] = 1'b0; uclr_p[i] = 1'b0; cur[i] = '0;
      model_reset(i);
    end
    ticks(3);
    chk("reset_s_out", 0, 64'(s_out_v[0]), 64'd0);
    chk("reset_underrun", 0, 64'(ur_v[0]), 64'd0);

    // Reset release and a first transfer on the 3-lane LSB-first instance.
    rst_n_v[0] = 1'b1; enable_v[0] = 1'b1; p_valid_v[0] = 1'b1;
    p_data_v[0] = {34'd0, 10'h3F0, 10'h155, 10'h2AB};
    #1 chk("ready_cycle0", 0, 64'(p_ready_v[0]), 64'd1);
    for (int k = 0; k < 10; k++) begin                 // cycles 1..10
      tick();
      if (k == 0) p_data_v[0] = {34'd0, 10'h111, 10'h3FF, 10'h0F0};
      chk("lane0_bit", 0, 64'(s_out_v[0][0]), 64'(exp_l0[k]));
      chk("ws_first_only", 0, 64'(ws_v[0]), 64'(k == 0));
    end
    chk("ready_cycle10", 0, 64'(p_ready_v[0]), 64'd1);
    tick();                                            // cycle 11
    p_valid_v[0] = 1'b0;
    ticks(9);                                          // cycle 20
    chk("ready_cycle20", 0, 64'(p_ready_v[0]), 64'd1);
    chk("ur_before", 0, 64'(ur_v[0]), 64'd0);

    // Underrun: idle symbol on every lane, sticky flag.
    for (int k = 0; k < 10; k++) begin                 // cycles 21..30
      tick();
      chk("idle_bits", 0, 64'(s_out_v[0]), 64'({1'b0, {3{exp_idle[k]}}}));
      if (k == 0) chk("ur_rise", 0, 64'(ur_v[0]), 64'd1);
    end
    uclr_v[0] = 1'b1;                                  // coincides with a second underrun
    tick();                                            // cycle 31
    chk("ur_set_wins", 0, 64'(ur_v[0]), 64'd1);
    uclr_v[0] = 1'b0;
    tick();                                            // cycle 32
    uclr_v[0] = 1'b1;
    tick();                                            // cycle 33
    chk("ur_clr_alone", 0, 64'(ur_v[0]), 64'd0);
    uclr_v[0] = 1'b0;

    // Enable stall at cnt = 4 stretches the word period to 13.
    p_valid_v[0] = 1'b1;
    p_data_v[0] = {34'd0, 10'h2D3, 10'h0CC, 10'h1E7};
    ticks(7);                                          // cycle 40
    chk("ready_cycle40", 0, 64'(p_ready_v[0]), 64'd1);
    tick();                                            // cycle 41
    p_valid_v[0] = 1'b0;
    ticks(4);                                          // cycle 45, cnt = 4
    enable_v[0] = 1'b0;
    s_hold = s_out_v[0];
    ws_hold = ws_v[0];
    for (int k = 0; k < 3; k++) begin                  // cycles 46..48
      tick();
      chk("stall_s_out", 0, 64'(s_out_v[0]), 64'(s_hold));
      chk("stall_ws", 0, 64'(ws_v[0]), 64'(ws_hold));
      chk("stall_ready", 0, 64'(p_ready_v[0]), 64'd0);
    end
    enable_v[0] = 1'b1;
    ticks(4);                                          // cycle 52
    chk("ready_not_yet", 0, 64'(p_ready_v[0]), 64'd0);
    tick();                                            // cycle 53
    chk("ready_period13", 0, 64'(p_ready_v[0]), 64'd1);

    // Idle load at 53 sets underrun; clear at cnt = 6 wipes everything.
    ticks(7);                                          // cycle 60
    chk("ur_before_clear", 0, 64'(ur_v[0]), 64'd1);
    clear_v[0] = 1'b1;
    #1 chk("ready_in_clear", 0, 64'(p_ready_v[0]), 64'd0);
    tick();                                            // cycle 61
    chk("clear_s_out", 0, 64'(s_out_v[0]), 64'd0);
    chk("clear_ur", 0, 64'(ur_v[0]), 64'd0);
    clear_v[0] = 1'b0;
    p_valid_v[0] = 1'b1;
    p_data_v[0] = {34'd0, 10'h3FF, 10'h3FF, 10'h3FF};
    #1 chk("ready_after_clear", 0, 64'(p_ready_v[0]), 64'd1);
    ticks(3);                                          // cycle 64
    chk("ones_before_rst", 0, 64'(s_out_v[0]), 64'd7);
    #2 rst_n_v[0] = 1'b0;
    #1 chk("async_rst_s_out", 0, 64'(s_out_v[0]), 64'd0);
    chk("async_rst_ws", 0, 64'(ws_v[0]), 64'd0);
    tick();
    rst_n_v[0] = 1'b1; enable_v[0] = 1'b0; p_valid_v[0] = 1'b0;

    // MSB-first single lane.
    rst_n_v[1] = 1'b1; enable_v[1] = 1'b1; p_valid_v[1] = 1'b1;
    p_data_v[1] = 64'(10'b1000000001);
    #1 chk("msb_ready", 1, 64'(p_ready_v[1]), 64'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) p_valid_v[1] = 1'b0;
      chk("msb_bit", 1, 64'(s_out_v[1][0]), 64'(exp_msb[k]));
    end
    ticks(12);
    enable_v[1] = 1'b0;

    // Parameter sweep with random valid gaps.
    rst_n_v[2] = 1'b1; enable_v[2] = 1'b1;
    rst_n_v[3] = 1'b1; enable_v[3] = 1'b1;
    for (int n = 0; n < 300; n++) begin
      p_valid_v[2] = ($urandom_range(0, 2) != 0);
      p_data_v[2]  = 64'($urandom_range(0, 3));
      uclr_v[2]    = ($urandom_range(0, 15) == 0);
      p_valid_v[3] = ($urandom_range(0, 3) != 0);
      p_data_v[3]  = {$urandom, $urandom};
      enable_v[3]  = ($urandom_range(0, 7) != 0);
      uclr_v[3]    = ($urandom_range(0, 15) == 0);
      tick();
    end
    enable_v[2] = 1'b0; enable_v[3] = 1'b0;
    ticks(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
